// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// This is the control FSM and MM:SS time register for the stopwatch. It takes
// the 1 Hz and 2 Hz single-cycle tick enables from the clock divider and the
// debounced button pulses. It sequences RUN / PAUSE / ADJUST and produces the
// displayed time together with per-field blank strobes, which blink the field
// being adjusted.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst          in   1      synchronous reset, active low
//   one_hz_tick  in   1      1-cycle pulse; counting enable in RUN
//   two_hz_tick  in   1      1-cycle pulse; increment / blink enable in ADJUST
//   pause_pulse  in   1      1-cycle pulse; toggles RUN <-> PAUSE
//   clr_pulse    in   1      1-cycle pulse; zeroes the time value
//   adj          in   1      level; 1 requests adjust mode
//   sel          in   1      level; 0 adjusts minutes, 1 adjusts seconds
//   minutes      out  MIN_W  current minutes, 0..MAX_MIN
//   seconds      out  SEC_W  current seconds, 0..MAX_SEC
//   running      out  1      1 while in RUN
//   blank_min    out  1      1 blanks the minutes digits this cycle
//   blank_sec    out  1      1 blanks the seconds digits this cycle
//
// Handshake note: there is no valid/ready flow here. Every input is either a
// single-cycle pulse that is consumed at the edge where it is high, or a level
// that is sampled at every edge. All outputs come straight from flops, so an
// input sampled at edge N shows up on the outputs right after edge N.
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int MAX_MIN = 99,
   parameter int MAX_SEC = 59,
   parameter int MIN_W   = 7,
   parameter int SEC_W   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             one_hz_tick,
   input  logic             two_hz_tick,
   input  logic             pause_pulse,
   input  logic             clr_pulse,
   input  logic             adj,
   input  logic             sel,
   output logic [MIN_W-1:0] minutes,
   output logic [SEC_W-1:0] seconds,
   output logic             running,
   output logic             blank_min,
   output logic             blank_sec
);

   localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MIN);
   localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(MAX_SEC);
   localparam logic [MIN_W-1:0] MIN_ONE  = MIN_W'(1);
   localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSE  = 2'd1,
      ST_ADJUST = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [MIN_W-1:0] min_q, min_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic             phase_q, phase_d;
   logic             running_q, running_d;
   logic             blank_min_q, blank_min_d;
   logic             blank_sec_q, blank_sec_d;

   // Wrapping increments of each field. These are shared by the RUN count
   // path (with carry) and the ADJUST path (without carry).
   logic [MIN_W-1:0] min_inc;
   logic [SEC_W-1:0] sec_inc;
   logic             sec_at_last;

   always_comb begin
      sec_at_last = (sec_q == SEC_LAST);
      sec_inc     = sec_at_last ? '0 : sec_q + SEC_ONE;
      min_inc     = (min_q == MIN_LAST) ? '0 : min_q + MIN_ONE;
   end

   // --------------------------------------------------------------------------
   // State register and all output flops
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         min_q       <= '0;
         sec_q       <= '0;
         phase_q     <= 1'b0;
         running_q   <= 1'b1;
         blank_min_q <= 1'b0;
         blank_sec_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         phase_q     <= phase_d;
         running_q   <= running_d;
         blank_min_q <= blank_min_d;
         blank_sec_q <= blank_sec_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and datapath logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      min_d       = min_q;
      sec_d       = sec_q;
      phase_d     = phase_q;
      running_d   = running_q;
      blank_min_d = 1'b0;
      blank_sec_d = 1'b0;

      // The action is chosen by the current state. A transition requested in
      // the same cycle takes effect at this edge, but it does not suppress the
      // action of the current state.
      case (state_q)
         ST_RUN: begin
            if (one_hz_tick) begin
               sec_d = sec_inc;
               if (sec_at_last) begin
                  min_d = min_inc;
               end
            end
            if (adj) begin
               state_d = ST_ADJUST;
            end else if (pause_pulse) begin
               state_d = ST_PAUSE;
            end
         end

         ST_PAUSE: begin
            if (adj) begin
               state_d = ST_ADJUST;
            end else if (pause_pulse) begin
               state_d = ST_RUN;
            end
         end

         ST_ADJUST: begin
            // Only the field chosen by sel in this cycle moves, and there is
            // no carry between fields.
            if (two_hz_tick) begin
               if (sel) begin
                  sec_d = sec_inc;
               end else begin
                  min_d = min_inc;
               end
               phase_d = ~phase_q;
            end
            // Leaving adjust always parks in PAUSE, so that the user has to
            // restart the count explicitly.
            if (!adj) begin
               state_d = ST_PAUSE;
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase

      // A clear wins over the state action. It zeroes the time, and any tick
      // in the same cycle is dropped, including its effect on the blink phase.
      // State transitions are not affected.
      if (clr_pulse) begin
         min_d   = '0;
         sec_d   = '0;
         phase_d = phase_q;
      end

      // The blink phase is only meaningful inside ADJUST. Holding it at 0
      // everywhere else means that every entry into ADJUST starts with the
      // selected field visible.
      if (state_d != ST_ADJUST || state_q != ST_ADJUST) begin
         phase_d = 1'b0;
      end

      running_d   = (state_d == ST_RUN);
      blank_sec_d = (state_d == ST_ADJUST) &  sel & phase_d;
      blank_min_d = (state_d == ST_ADJUST) & ~sel & phase_d;
   end

   assign minutes   = min_q;
   assign seconds   = sec_q;
   assign running   = running_q;
   assign blank_min = blank_min_q;
   assign blank_sec = blank_sec_q;

   // --------------------------------------------------------------------------
   // Invariants on the registered outputs
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         assert (min_q <= MIN_LAST)
            else $error("minutes above MAX_MIN");
         assert (sec_q <= SEC_LAST)
            else $error("seconds above MAX_SEC");
         assert (!(blank_min_q && blank_sec_q))
            else $error("both fields blanked");
      end
   end

endmodule
